// File: rtl/updi_pkg.sv
// updi_pkg: shared UPDI opcodes, pointer/size encodings, NVMCTRL layout and writer error codes
package updi_pkg;
   typedef enum logic [2:0] {
      UPDI_LDS    = 3'd0,
      UPDI_LD     = 3'd1,
      UPDI_STS    = 3'd2,
      UPDI_ST     = 3'd3,
      UPDI_LDCS   = 3'd4,
      UPDI_REPEAT = 3'd5,
      UPDI_STCS   = 3'd6,
      UPDI_KEY    = 3'd7
   } updi_instruction;
   localparam logic [1:0] PTR_DEREF = 2'd0;
   localparam logic [1:0] PTR_INC = 2'd1;
   localparam logic [1:0] PTR_REG = 2'd2;
   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_WORD = 2'd1;
   localparam logic [15:0] NVMCTRL_CTRLA = 16'h0000;
   localparam logic [15:0] NVMCTRL_STATUS = 16'h0002;
   localparam logic [7:0] NVM_CMD_ERWP = 8'h03;
   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_ACK = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_WRERROR = 2'd3;
endpackage

// File: rtl/updi_page_buffer.sv
// updi_page_buffer: page-sized byte store with one write port and a flat little-endian read-out
module updi_page_buffer #(
   parameter int PAGE_SIZE = 64
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(PAGE_SIZE)-1:0] waddr,
   input  logic [7:0]                   wdata,
   output logic [PAGE_SIZE*8-1:0]       rdata
);
   logic [7:0] mem [PAGE_SIZE];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   for (genvar i = 0; i < PAGE_SIZE; i++) begin : g_rd
      assign rdata[8*i +: 8] = mem[i];
   end
endmodule

// File: rtl/updi_nvm_page_writer.sv
// updi_nvm_page_writer: loads one flash page over UPDI, issues ERWP and polls NVMCTRL.STATUS
module updi_nvm_page_writer
   import updi_pkg::*;
#(
   parameter int PAGE_SIZE = 64,
   parameter logic [15:0] NVMCTRL_BASE = 16'h1000,
   parameter int POLL_LIMIT = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [15:0]                  page_addr,
   input  logic [$clog2(PAGE_SIZE):0]   page_len,
   output logic [$clog2(PAGE_SIZE)-1:0] src_addr,
   input  logic [7:0]                   src_data,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [1:0]                   err_code,
   output logic                         instr_converter_en,
   output logic [2:0]                   instruction,
   output logic [1:0]                   instr_ptr,
   output logic [1:0]                   instr_size_a,
   output logic [1:0]                   instr_size_b,
   output logic [PAGE_SIZE*8-1:0]       instr_data,
   output logic [$clog2(PAGE_SIZE):0]   instr_data_len,
   output logic [PAGE_SIZE-1:0]         instr_wait_ack_after,
   output logic                         tx_start,
   output logic                         rx_start,
   output logic [$clog2(PAGE_SIZE)-1:0] rx_n_bytes,
   input  logic                         tx_ready,
   input  logic                         rx_done,
   input  logic                         ack_error,
   input  logic [7:0]                   rx_fifo_data,
   input  logic                         rx_fifo_empty,
   output logic                         rx_fifo_rd_en
);
   localparam int AW = $clog2(PAGE_SIZE);
   localparam int LW = AW + 1;
   localparam int PW = $clog2(POLL_LIMIT + 1);
   localparam logic [15:0] CTRLA_ADDR = NVMCTRL_BASE + NVMCTRL_CTRLA;
   localparam logic [15:0] STATUS_ADDR = NVMCTRL_BASE + NVMCTRL_STATUS;
   typedef enum logic [3:0] {
      IDLE, FETCH, PTR_L, PTR_W, REP_L, REP_W, INC_L, INC_W,
      CMD_L, CMD_W, POLL_L, POLL_W, CHECK, DONE, ERROR
   } state_t;
   state_t state;
   logic [15:0] addr_r;
   logic [LW-1:0] len_r, cnt;
   logic [PW-1:0] poll_cnt;
   logic rx_seen;
   logic [PAGE_SIZE*8-1:0] buf_data;
   logic in_wait;
   logic unused_status;
   assign unused_status = ^rx_fifo_data[7:3];
   assign in_wait = state inside {PTR_W, REP_W, INC_W, CMD_W, POLL_W};
   updi_page_buffer #(.PAGE_SIZE(PAGE_SIZE)) u_buf (
      .clk(clk),
      .we(state == FETCH && cnt != '0),
      .waddr(AW'(cnt - 1'b1)),
      .wdata(src_data),
      .rdata(buf_data)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         err_code <= ERR_NONE;
         addr_r <= '0;
         len_r <= '0;
         cnt <= '0;
         poll_cnt <= '0;
         rx_seen <= 1'b0;
      end else begin
         if (in_wait && ack_error) err_code <= ERR_ACK;
         case (state)
            IDLE: if (start) begin
               addr_r <= page_addr;
               len_r <= page_len > LW'(PAGE_SIZE) ? LW'(PAGE_SIZE) : page_len;
               cnt <= '0;
               poll_cnt <= '0;
               err_code <= ERR_NONE;
               state <= page_len == '0 ? DONE : FETCH;
            end
            FETCH: begin
               cnt <= cnt + 1'b1;
               if (cnt == len_r) state <= PTR_L;
            end
            PTR_L: state <= PTR_W;
            PTR_W: state <= ack_error ? ERROR : tx_ready ? REP_L : PTR_W;
            REP_L: state <= REP_W;
            REP_W: state <= ack_error ? ERROR : tx_ready ? INC_L : REP_W;
            INC_L: state <= INC_W;
            INC_W: state <= ack_error ? ERROR : tx_ready ? CMD_L : INC_W;
            CMD_L: state <= CMD_W;
            CMD_W: state <= ack_error ? ERROR : tx_ready ? POLL_L : CMD_W;
            POLL_L: begin
               poll_cnt <= poll_cnt == PW'(POLL_LIMIT) ? poll_cnt : poll_cnt + 1'b1;
               rx_seen <= 1'b0;
               state <= POLL_W;
            end
            POLL_W: if (ack_error) state <= ERROR;
               else if (rx_fifo_rd_en) begin
                  rx_seen <= 1'b0;
                  state <= CHECK;
               end else if (rx_done) rx_seen <= 1'b1;
            // the popped STATUS byte is valid here, one cycle after rd_en
            CHECK: if (rx_fifo_data[2]) begin
                  err_code <= ERR_WRERROR;
                  state <= ERROR;
               end else if (rx_fifo_data[1:0] != 2'b00) begin
                  if (poll_cnt < PW'(POLL_LIMIT)) state <= POLL_L;
                  else begin
                     err_code <= ERR_TIMEOUT;
                     state <= ERROR;
                  end
               end else state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end
   always_comb begin
      busy = state != IDLE;
      done = state == DONE;
      error = state == ERROR;
      src_addr = state == FETCH ? cnt[AW-1:0] : '0;
      tx_start = state inside {PTR_L, REP_L, INC_L, CMD_L, POLL_L};
      instr_converter_en = tx_start;
      rx_start = state == POLL_L;
      rx_fifo_rd_en = state == POLL_W && rx_seen && !rx_fifo_empty;
      instruction = 3'd0;
      instr_ptr = 2'd0;
      instr_size_a = SIZE_BYTE;
      instr_size_b = SIZE_BYTE;
      instr_data = '0;
      instr_data_len = '0;
      instr_wait_ack_after = '0;
      rx_n_bytes = '0;
      case (state)
         PTR_L, PTR_W: begin
            instruction = UPDI_ST;
            instr_ptr = PTR_REG;
            instr_size_b = SIZE_WORD;
            instr_data[15:0] = addr_r;
            instr_data_len = LW'(2);
            instr_wait_ack_after[1] = 1'b1;
         end
         REP_L, REP_W: begin
            instruction = UPDI_REPEAT;
            instr_data[7:0] = 8'(len_r - 1'b1);
            instr_data_len = LW'(1);
         end
         INC_L, INC_W: begin
            instruction = UPDI_ST;
            instr_ptr = PTR_INC;
            instr_data = buf_data;
            instr_data_len = len_r;
            for (int i = 0; i < PAGE_SIZE; i++) instr_wait_ack_after[i] = LW'(i) < len_r;
         end
         CMD_L, CMD_W: begin
            instruction = UPDI_STS;
            instr_size_a = SIZE_WORD;
            instr_data[23:0] = {NVM_CMD_ERWP, CTRLA_ADDR};
            instr_data_len = LW'(3);
            instr_wait_ack_after[2:1] = 2'b11;
         end
         POLL_L, POLL_W: begin
            instruction = UPDI_LDS;
            instr_size_a = SIZE_WORD;
            instr_data[15:0] = STATUS_ADDR;
            instr_data_len = LW'(2);
            rx_n_bytes = AW'(1);
         end
         default: ;
      endcase
   end
endmodule
